// File: rtl/spi_dac_scheduler_if.sv
// Channel sample inputs, sample-rate control and SPI DAC outputs of the
// spi_dac_scheduler; master drives samples/config, slave is the scheduler.
interface spi_dac_scheduler_if;
  logic [11:0] period;
  logic [47:0] ch_data;
  logic [3:0]  ch_wr;
  logic [3:0]  ch_enable;
  logic        spi_sck;
  logic        spi_sdo;
  logic        spi_dac_cs;
  logic        frame_tick;
  logic        busy;
  logic        overrun;

  modport master (
    output period, ch_data, ch_wr, ch_enable,
    input  spi_sck, spi_sdo, spi_dac_cs, frame_tick, busy, overrun
  );

  modport slave (
    input  period, ch_data, ch_wr, ch_enable,
    output spi_sck, spi_sdo, spi_dac_cs, frame_tick, busy, overrun
  );
endinterface

// File: rtl/spi_dac_scheduler.sv
// Sample-period tick generator and A-to-D arbiter that serialises one 24-bit
// write-and-update frame per pending, enabled channel to an LTC2624 SPI DAC.
module spi_dac_scheduler (
  input  logic              clk,
  input  logic              reset,
  spi_dac_scheduler_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [1:0]  state;
  logic [11:0] counter;
  logic [11:0] hold   [4];
  logic [11:0] shadow [4];
  logic [3:0]  dirty;
  logic [3:0]  mask;
  logic [5:0]  cnt;
  logic [22:0] sr;

  logic        tick_now;
  logic        gap_done;
  logic        can_snap;
  logic        snap;
  logic [3:0]  snap_mask;
  logic [1:0]  sel;
  logic [23:0] frame;

  // The last GAP clock with nothing left queued counts as idle, so a tick
  // landing exactly when a batch finishes starts the next batch seamlessly.
  always_comb begin
    tick_now  = (counter == 12'd0);
    gap_done  = (state == ST_GAP) && (cnt == 6'd1);
    can_snap  = (state == ST_IDLE) || (gap_done && (mask == 4'd0));
    snap      = tick_now && can_snap;
    snap_mask = dirty & bus.ch_enable;
  end

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise a path that skips it infers a latch.
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) sel = 2'(i);
    end
    frame = {4'b0011, 2'b00, sel, shadow[sel], 4'h0};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff reads pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter        <= 12'd0;
      bus.frame_tick <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.frame_tick <= tick_now;
      bus.overrun    <= tick_now && !can_snap;
      counter        <= tick_now ? (bus.period - 12'd1) : (counter - 12'd1);
    end
  end

  // NOTE: these are small flop arrays, not RAMs, so resetting them is cheap
  // and keeps a post-reset tick from sending stale samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        hold[i]   <= 12'd0;
        shadow[i] <= 12'd0;
      end
      dirty <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (snap) shadow[i] <= hold[i];
        if (bus.ch_wr[i]) begin
          hold[i]  <= bus.ch_data[12*i +: 12];
          dirty[i] <= 1'b1;
        end else if (snap && snap_mask[i]) begin
          dirty[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      mask           <= 4'd0;
      cnt            <= 6'd0;
      sr             <= 23'd0;
      bus.spi_sck    <= 1'b0;
      bus.spi_sdo    <= 1'b0;
      bus.spi_dac_cs <= 1'b1;
      bus.busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_LOAD: begin
          sr             <= frame[22:0];
          bus.spi_sdo    <= frame[23];
          bus.spi_dac_cs <= 1'b0;
          mask[sel]      <= 1'b0;
          cnt            <= 6'd0;
          state          <= ST_SHIFT;
        end
        ST_SHIFT: begin
          cnt <= cnt + 6'd1;
          if (!cnt[0]) begin
            bus.spi_sck <= 1'b1;
          end else begin
            // Data only moves on the falling half so the DAC sees stable sdo.
            bus.spi_sck <= 1'b0;
            sr          <= {sr[21:0], 1'b0};
            bus.spi_sdo <= sr[22];
            if (cnt == 6'd47) begin
              bus.spi_sdo    <= 1'b0;
              bus.spi_dac_cs <= 1'b1;
              cnt            <= 6'd0;
              state          <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          cnt <= cnt + 6'd1;
          if (gap_done) begin
            if (mask != 4'd0) begin
              state <= ST_LOAD;
            end else begin
              state    <= ST_IDLE;
              bus.busy <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (snap) begin
        mask <= snap_mask;
        if (snap_mask != 4'd0) begin
          state    <= ST_LOAD;
          bus.busy <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/spi_dac_scheduler.md
# spi_dac_scheduler

Sample-rate scheduler and 4-channel arbiter for the Spartan-3E starter-kit SPI DAC (LTC2624, channels A-D). Each synth voice/output owns one channel. It posts 12-bit samples through a write strobe. The scheduler generates the programmable sample-period tick. On each tick it snapshots pending samples and serialises one 24-bit write-and-update frame per pending, enabled channel, in fixed A-to-D order, on a single shared SPI bus.

## Interface
Parameters: none. The channel count (4), SCK rate (clk/2) and frame format are fixed.

- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- period  in  12  clocks per sample period; 0 means 4096
- ch_data  in  48  channel i sample at [12i+11:12i]
- ch_wr  in  4  per-channel write strobe; captures ch_data slice into the holding register and sets dirty[i]
- ch_enable  in  4  channel i may be scheduled
- spi_sck  out  1  SPI clock, idles low
- spi_sdo  out  1  SPI data, MSB first
- spi_dac_cs  out  1  DAC chip select, active low
- frame_tick  out  1  one-clock pulse at the start of each sample period
- busy  out  1  high while any frame is in progress
- overrun  out  1  one-clock pulse when a tick arrives while busy

## Operation
- **Period counter:** 12-bit down-counter. At 0 it emits frame_tick and reloads with period-1 (4095 when period=0). A change to period takes effect at the next reload.
- **Holding registers:** hold[i] (12 b) and dirty[i].
  - ch_wr[i] loads hold[i] and sets dirty[i].
  - If ch_wr[i] coincides with a snapshot edge, the write wins: dirty[i] stays set and the new value is not in the current snapshot.
- **Snapshot (tick edge, only when FSM is IDLE):**
  - mask = dirty & ch_enable, computed from pre-edge values.
  - shadow[i] = hold[i].
  - dirty[i] is cleared for every bit set in mask.
  - Disabled dirty channels keep their dirty bit.
- **Tick while busy:** no snapshot, overrun pulses, and dirty bits are retained for the next tick.
- **FSM states:** IDLE, LOAD, SHIFT, GAP.
  - IDLE -> LOAD on a tick with mask nonzero.
  - LOAD (1 clk): select the lowest set mask bit n, load the shift register, and clear mask[n].
  - SHIFT: 48 clks.
  - GAP: 2 clks.
  - At the end of GAP: go to LOAD if mask is nonzero, else IDLE.
- **Frame format:** {4'b0011, 4'b00nn, shadow[n], 4'h0}. Example: channel 1 = 0xABC gives 0x31ABC0.
- **SHIFT detail:** bit k (k=0 is the MSB) is held for 2 clks, with sck low in the first clk and high in the second. The DAC samples on the sck rising edge. sdo changes only while sck is low.
- **Reset:** all outputs take their reset values immediately (asynchronous), including mid-frame. The aborted frame is discarded.
- **Reset values:** spi_sck=0, spi_sdo=0, spi_dac_cs=1, frame_tick=0, busy=0, overrun=0. hold, dirty, mask, shadow and counter are all 0, and the FSM is in IDLE.

## Timing
- After reset release, the counter is 0, so the first frame_tick occurs in the first cycle after release. Thereafter ticks are exactly period clocks apart (4096 when period=0).
- Relative to tick cycle T with mask nonzero:
  - T: state LOAD; busy=1, cs=1.
  - T+1..T+48: cs=0. Bit k is driven in cycles T+1+2k and T+2+2k, with sck=1 in T+2+2k.
  - T+49, T+50: cs=1, sck=0 (CS rising edge at T+49 updates the DAC).
  - T+51: next LOAD, or IDLE with busy=0.
- Frame length is 51 clks, so N frames take 51N clks. A period of 204 or more never overruns.
- Mask empty at tick: no SPI activity; busy stays 0; frame_tick still pulses.
- frame_tick and overrun are single-cycle pulses.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset values:** assert reset mid-SHIFT -> same cycle cs=1, sck=0, busy=0. After release, the first tick occurs with no transfer (dirty=0).
- **Single channel:** period=100, ch_wr[1] with 0xABC -> next tick gives 24 sck rising edges capturing 0x31ABC0, cs low exactly 48 clks, busy exactly 51 clks. The following tick gives no transfer.
- **All four channels:** all four dirty and enabled, data 0x111/0x222/0x333/0x444 -> frames 0x301110, 0x312220, 0x323330, 0x334440 in order, busy 204 clks.
- **Disabled channel:** ch_enable[2]=0 with ch 2 dirty -> no frame for ch 2. Enable it before the next tick -> frame for ch 2 sent on that tick.
- **Overrun:** period=150, all four channels rewritten every period -> tick at T+150 while busy gives a one-clock overrun pulse and no snapshot. Those channels are sent at the following tick.
- **Write on snapshot edge:** ch_wr[0] with 0x0FF in the same edge as the tick, with 0xF00 previously pending -> 0x30F000 sent now. 0x300FF0 is sent at the next tick.
